// File: rtl/lpc_pkg.sv
// Shared types and LAD nibble constants for the LPC target driver.
// The state enum and the SYNC/TAR codes live here.
package lpc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HTAR,
      SYNC,
      DATA,
      TTAR0,
      TTAR1,
      ERR
   } lpc_state_e;

   localparam logic [3:0] SYNC_READY = 4'h0;
   localparam logic [3:0] SYNC_LWAIT = 4'h6;
   localparam logic [3:0] SYNC_ERR   = 4'hA;
   localparam logic [3:0] TAR_NIB    = 4'hF;

endpackage

// File: rtl/lpc_target_driver_if.sv
// Cycle control, backend and LAD-drive signals of the LPC target driver.
// master is the decoder/backend side, slave is the driver itself.
interface lpc_target_driver_if #(
   parameter int MAX_BYTES = 4
);

   logic                   Start;
   logic                   Claim;
   logic                   Opcode;
   logic [1:0]             ByteCnt;
   logic                   WaitReq;
   logic [8*MAX_BYTES-1:0] DataRd;
   logic                   Abort;
   logic [3:0]             LpcOut;
   logic                   LpcOe;
   logic                   Busy;
   logic                   Done;

   modport master (
      output Start, Claim, Opcode, ByteCnt,
      output WaitReq, DataRd, Abort,
      input  LpcOut, LpcOe, Busy, Done
   );

   modport slave (
      input  Start, Claim, Opcode, ByteCnt,
      input  WaitReq, DataRd, Abort,
      output LpcOut, LpcOe, Busy, Done
   );

endinterface

// File: rtl/lpc_sync_timer.sv
// Saturating count of long-wait SYNC nibbles with its
// minimum-wait and error-limit compares.
module lpc_sync_timer #(
   parameter int WAIT_CYCLES = 0,
   parameter int MAX_WAIT    = 8,
   localparam int W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic min_met,
   output logic at_limit
);

   localparam int WMIN =
      (WAIT_CYCLES < MAX_WAIT) ? WAIT_CYCLES : MAX_WAIT;
   localparam logic [W-1:0] LIM  = W'(MAX_WAIT);
   localparam logic [W-1:0] MINC = W'(WMIN);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // clr and inc together restart the count at one
   always_comb begin
      cnt_d = clr ? '0 : cnt_q;
      if (inc && cnt_d != LIM)
         cnt_d = cnt_d + W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign min_met  = cnt_q >= MINC;
   assign at_limit = cnt_q >= LIM;

endmodule

// File: rtl/lpc_target_driver.sv
// LPC target response sequencer: host TAR, SYNC, read data,
// target TAR, with long-wait timeout and host abort.
module lpc_target_driver
   import lpc_pkg::*;
#(
   parameter int MAX_BYTES   = 4,
   parameter int WAIT_CYCLES = 0,
   parameter int MAX_WAIT    = 8
) (
   input logic           LpcClock,
   input logic           PciReset,
   lpc_target_driver_if.slave bus
);

   localparam int NW = $clog2(2 * MAX_BYTES);
   localparam int DW = 8 * MAX_BYTES;

   lpc_state_e    state_q, state_d;
   logic          htar_q, htar_d;
   logic          op_q, op_d;
   logic [1:0]    bc_q, bc_d;
   logic [NW-1:0] nib_q, nib_d;
   logic [DW-1:0] data_q, data_d;
   logic [3:0]    out_q, out_d;
   logic          oe_q, oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          tmr_clr;
   logic          tmr_inc;
   logic          min_met;
   logic          at_limit;
   logic          do_sync;
   logic [1:0]    bc_in;
   logic [NW-1:0] nib_inc;
   logic [NW-1:0] nib_last;

   lpc_sync_timer #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .MAX_WAIT    (MAX_WAIT)
   ) u_timer (
      .clk      (LpcClock),
      .rst_n    (PciReset),
      .clr      (tmr_clr),
      .inc      (tmr_inc),
      .min_met  (min_met),
      .at_limit (at_limit)
   );

   assign bc_in = (int'(bus.ByteCnt) >= MAX_BYTES)
                ? 2'(MAX_BYTES - 1) : bus.ByteCnt;
   assign nib_inc  = nib_q + NW'(1);
   assign nib_last = NW'({bc_q, 1'b1});
   assign tmr_clr  = state_q != SYNC;

   always_comb begin
      state_d = state_q;
      htar_d  = htar_q;
      op_d    = op_q;
      bc_d    = bc_q;
      nib_d   = nib_q;
      data_d  = data_q;
      out_d   = 4'h0;
      oe_d    = 1'b0;
      done_d  = 1'b0;
      tmr_inc = 1'b0;
      do_sync = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.Start && bus.Claim) begin
               state_d = HTAR;
               htar_d  = 1'b0;
               op_d    = bus.Opcode;
               bc_d    = bc_in;
            end
         end
         HTAR: begin
            if (!htar_q)
               htar_d = 1'b1;
            else
               do_sync = 1'b1;
         end
         SYNC: begin
            if (out_q != SYNC_READY) begin
               do_sync = 1'b1;
            end else if (op_q) begin
               state_d = TTAR0;
               out_d   = TAR_NIB;
               oe_d    = 1'b1;
            end else begin
               state_d = DATA;
               nib_d   = '0;
               out_d   = data_q[3:0];
               oe_d    = 1'b1;
            end
         end
         DATA: begin
            oe_d = 1'b1;
            if (nib_q == nib_last) begin
               state_d = TTAR0;
               out_d   = TAR_NIB;
            end else begin
               nib_d = nib_inc;
               out_d = data_q[{nib_inc, 2'b00} +: 4];
            end
         end
         ERR: begin
            state_d = TTAR0;
            out_d   = TAR_NIB;
            oe_d    = 1'b1;
         end
         TTAR0: begin
            state_d = TTAR1;
            done_d  = 1'b1;
         end
         TTAR1: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // next SYNC nibble: timeout, long wait, or ready
      if (do_sync) begin
         state_d = SYNC;
         oe_d    = 1'b1;
         if (at_limit) begin
            state_d = ERR;
            out_d   = SYNC_ERR;
         end else if (bus.WaitReq || !min_met) begin
            out_d   = SYNC_LWAIT;
            tmr_inc = 1'b1;
         end else begin
            out_d  = SYNC_READY;
            data_d = bus.DataRd;
         end
      end

      if (bus.Abort) begin
         state_d = IDLE;
         out_d   = 4'h0;
         oe_d    = 1'b0;
         done_d  = 1'b0;
         tmr_inc = 1'b0;
      end

      busy_d = state_d != IDLE;
   end

   always_ff @(posedge LpcClock) begin
      if (!PciReset) begin
         state_q <= IDLE;
         htar_q  <= 1'b0;
         op_q    <= 1'b0;
         bc_q    <= '0;
         nib_q   <= '0;
         data_q  <= '0;
         out_q   <= 4'h0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         htar_q  <= htar_d;
         op_q    <= op_d;
         bc_q    <= bc_d;
         nib_q   <= nib_d;
         data_q  <= data_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.LpcOut = out_q;
   assign bus.LpcOe  = oe_q;
   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;

endmodule

// File: tb/tb_lpc_target_driver.sv
// Scoreboard bench for lpc_target_driver: per-clock expected
// {Busy,Done,LpcOe,LpcOut} queued at stimulus, popped each cycle.
module tb_lpc_target_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        start, claim, opcode, waitreq, abort;
   logic [1:0]  bytecnt;
   logic [31:0] data;

   int n_vec = 0;
   int n_err = 0;
   logic [6:0] exp_q[$];

   always #5 clk = ~clk;

   lpc_target_driver_if #(.MAX_BYTES(4)) ia ();
   lpc_target_driver_if #(.MAX_BYTES(2)) ib ();

   assign ia.Start   = start & ~sel;
   assign ia.Claim   = claim;
   assign ia.Opcode  = opcode;
   assign ia.ByteCnt = bytecnt;
   assign ia.WaitReq = waitreq;
   assign ia.DataRd  = data;
   assign ia.Abort   = abort;
   assign ib.Start   = start & sel;
   assign ib.Claim   = claim;
   assign ib.Opcode  = opcode;
   assign ib.ByteCnt = bytecnt;
   assign ib.WaitReq = waitreq;
   assign ib.DataRd  = data[15:0];
   assign ib.Abort   = abort;

   lpc_target_driver #(
      .MAX_BYTES(4), .WAIT_CYCLES(0), .MAX_WAIT(8)
   ) dut_a (
      .LpcClock (clk),
      .PciReset (rst_n),
      .bus      (ia.slave)
   );

   lpc_target_driver #(
      .MAX_BYTES(2), .WAIT_CYCLES(2), .MAX_WAIT(8)
   ) dut_b (
      .LpcClock (clk),
      .PciReset (rst_n),
      .bus      (ib.slave)
   );

   logic [6:0] obs_a, obs_b, obs;
   assign obs_a = {ia.Busy, ia.Done, ia.LpcOe, ia.LpcOut};
   assign obs_b = {ib.Busy, ib.Done, ib.LpcOe, ib.LpcOut};
   assign obs   = sel ? obs_b : obs_a;

   task automatic chk(input string tag,
                      input logic [6:0] got,
                      input logic [6:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h (busy,done,oe,nib)",
                  tag, got, want);
      end
   endtask

   function automatic logic [6:0] ex(input bit b, input bit d,
                                     input bit o,
                                     input logic [3:0] n);
      return {b, d, o, n};
   endfunction

   task automatic push(input logic [6:0] v, input int n = 1);
      repeat (n) exp_q.push_back(v);
   endtask

   task automatic p_htar();
      push(ex(1, 0, 0, 4'h0), 2);
   endtask

   task automatic p_nib(input logic [3:0] n);
      push(ex(1, 0, 1, n));
   endtask

   task automatic p_tail();
      p_nib(4'hF);
      push(ex(1, 1, 0, 4'h0));
      push(ex(0, 0, 0, 4'h0));
   endtask

   // Drives Start at the current negedge, then one cycle per queued item.
   task automatic run_txn(input string tag, input bit d_sel,
                          input bit cl, input bit op,
                          input logic [1:0] bc,
                          input logic [31:0] d,
                          input int nw, input int ab_k,
                          input int rs_k, input int st_k);
      int k;
      logic [6:0] e;
      sel     = d_sel;
      start   = 1'b1;
      claim   = cl;
      opcode  = op;
      bytecnt = bc;
      data    = d;
      waitreq = nw > 0;
      abort   = ab_k == 0;
      rst_n   = 1'b1;
      k = 0;
      while (exp_q.size() != 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         chk($sformatf("%s[%0d]", tag, k), obs, e);
         if (exp_q.size() == 0) break;
         k++;
         start   = k == st_k;
         waitreq = k < 2 + nw;
         abort   = k == ab_k;
         rst_n   = !(k == rs_k);
      end
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; start = 1'b1; claim = 1'b1;
      opcode = 1'b0; bytecnt = 2'd0; waitreq = 1'b0;
      abort = 1'b0; data = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_a", obs_a, 7'h00);
      chk("rst_b", obs_b, 7'h00);
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("idle_a", obs_a, 7'h00);
      chk("idle_b", obs_b, 7'h00);

      // read 1 byte, no wait
      p_htar(); p_nib(4'h0); p_nib(4'h5); p_nib(4'hA); p_tail();
      run_txn("rd1", 0, 1, 0, 2'd0, 32'h0000_00A5, 0, -1, -1, -1);

      // read 4 bytes, 3 wait clocks, stray Start mid-DATA ignored
      p_htar();
      repeat (3) p_nib(4'h6);
      p_nib(4'h0);
      for (int i = 8; i >= 1; i--) p_nib(4'(i));
      p_tail();
      run_txn("rd4", 0, 1, 0, 2'd3, 32'h1234_5678, 3, -1, -1, 8);

      // write, WAIT_CYCLES=2 instance
      p_htar(); p_nib(4'h6); p_nib(4'h6); p_nib(4'h0); p_tail();
      run_txn("wr", 1, 1, 1, 2'd0, 32'h0, 0, -1, -1, -1);

      // ByteCnt=3 clamps to 2 bytes on MAX_BYTES=2
      p_htar(); p_nib(4'h6); p_nib(4'h6); p_nib(4'h0);
      p_nib(4'h4); p_nib(4'hD); p_nib(4'h3); p_nib(4'hC);
      p_tail();
      run_txn("clamp", 1, 1, 0, 2'd3, 32'h0000_C3D4, 0, -1, -1, -1);

      // WaitReq stuck: timeout to error SYNC
      p_htar();
      repeat (8) p_nib(4'h6);
      p_nib(4'hA);
      p_tail();
      run_txn("tmo", 0, 1, 0, 2'd0, 32'h0, 40, -1, -1, -1);

      // abort during 2nd DATA nibble
      p_htar(); p_nib(4'h0); p_nib(4'hF); p_nib(4'hE);
      push(ex(0, 0, 0, 4'h0));
      run_txn("abrt", 0, 1, 0, 2'd1, 32'h0000_BEEF, 0, 5, -1, -1);

      // unclaimed Start gets no response
      push(ex(0, 0, 0, 4'h0), 3);
      run_txn("noclm", 0, 0, 0, 2'd0, 32'h0, 0, -1, -1, -1);

      // Abort beats Start in IDLE
      push(ex(0, 0, 0, 4'h0), 2);
      run_txn("abst", 0, 1, 0, 2'd0, 32'h0, 0, 0, -1, -1);

      // reset during SYNC releases bus at once
      p_htar(); p_nib(4'h6); p_nib(4'h6);
      push(ex(0, 0, 0, 4'h0));
      run_txn("rsync", 0, 1, 0, 2'd0, 32'h0, 10, -1, 4, -1);

      // Start on first clock after reset release
      p_htar(); p_nib(4'h0); p_nib(4'h5); p_nib(4'hA); p_tail();
      run_txn("post", 0, 1, 0, 2'd0, 32'h0000_00A5, 0, -1, -1, -1);

      chk("other_b", obs_b, 7'h00);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lpc_target_driver.md
LPC_TARGET_DRIVER -- requirements
Module: lpc_target_driver

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 4, giving the maximum bytes per read cycle (legal values 1, 2, 4).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, giving the minimum long-wait SYNC nibbles before the ready SYNC.
REQ-003 The block SHALL have parameter MAX_WAIT, default 8, giving the long-wait SYNC count limit before an error SYNC is issued.
REQ-004 LpcClock  in  1  33 MHz LPC clock; the only clock.
REQ-005 PciReset  in  1  reset, synchronous and active-low.
REQ-006 Start  in  1  one-clock pulse on the first host-TAR clock of a decoded cycle.
REQ-007 Claim  in  1  address hit, sampled with Start.
REQ-008 Opcode  in  1  cycle type, sampled with Start: 0 read, 1 write.
REQ-009 ByteCnt  in  2  number of bytes minus 1, sampled with Start; values at or above MAX_BYTES clamp to MAX_BYTES-1.
REQ-010 WaitReq  in  1  backend not ready; extends SYNC while high.
REQ-011 DataRd  in  8*MAX_BYTES  read data, byte 0 in bits [7:0].
REQ-012 Abort  in  1  LFRAME# re-asserted by the host mid-cycle.
REQ-013 LpcOut  out  4  registered nibble for the LAD bus.
REQ-014 LpcOe  out  1  registered LAD drive enable.
REQ-015 Busy  out  1  high in every state other than IDLE.
REQ-016 Done  out  1  one-clock pulse when a cycle completes normally.

Function
REQ-017 The FSM SHALL have the states IDLE, HTAR, SYNC, DATA, TTAR0, TTAR1 and ERR.
REQ-018 IDLE SHALL go to HTAR only when Start=1 and Claim=1; when Start=1 and Claim=0 the block SHALL remain in IDLE with LpcOe=0.
REQ-019 HTAR SHALL last exactly 2 clocks with LpcOe=0; the first SYNC nibble SHALL appear on the bus in the 3rd clock after the edge that sampled Start.
REQ-020 In SYNC the block SHALL drive 0x6 while WaitReq=1 or fewer than WAIT_CYCLES long-wait nibbles have been driven, and SHALL otherwise drive 0x0 for one clock.
REQ-021 When the long-wait count reaches MAX_WAIT, the next clock SHALL drive 0xA (state ERR), skip DATA and go to TTAR0.
REQ-022 After the ready SYNC, a read SHALL go to DATA and a write SHALL go directly to TTAR0.
REQ-023 DataRd SHALL be latched on the clock that drives the ready SYNC; DATA SHALL drive 2*(ByteCnt+1) nibbles: byte 0 first, low nibble before high nibble.
REQ-024 TTAR0 SHALL drive 0xF with LpcOe=1.
REQ-025 TTAR1 SHALL hold LpcOe=0, pulse Done=1 (normal or error completion), and return to IDLE.
REQ-026 Start SHALL be ignored while Busy=1.
REQ-027 Abort=1 in any state SHALL force IDLE on the next edge with LpcOe=0 and no Done pulse; Abort has priority over Start.
REQ-028 When LpcOe=0, LpcOut SHALL be 0x0.
REQ-029 The wait counter SHALL be $clog2(MAX_WAIT+1) bits wide, saturating, and cleared on entry to SYNC.
REQ-030 The nibble counter SHALL be $clog2(2*MAX_BYTES) bits wide and cleared on entry to DATA.

Reset
REQ-031 On any LpcClock edge with PciReset=0, the block SHALL go to IDLE with LpcOe=0, LpcOut=0x0, Busy=0, Done=0, all counters 0 and the data latch 0.
REQ-032 A reset asserted mid-cycle SHALL release the bus on the next edge, with no TTAR and no Done.

Structure
REQ-033 Package lpc_pkg SHALL hold the FSM state enum and the constants SYNC_READY=4'h0, SYNC_LWAIT=4'h6, SYNC_ERR=4'hA and TAR_NIB=4'hF.
REQ-034 The wait counter and its limit compare SHALL be one sub-module, lpc_sync_timer; all other logic SHALL stay in lpc_target_driver.

Verification
REQ-035 Read, ByteCnt=0, DataRd[7:0]=0xA5, WaitReq=0 -> bus shows Z,Z,0x0,0x5,0xA,0xF,Z, then a Done pulse.
REQ-036 Read, ByteCnt=3, DataRd=0x12345678, WaitReq high for 3 clocks -> bus shows 6,6,6,0 then 8,7,6,5,4,3,2,1, then F.
REQ-037 Write with WAIT_CYCLES=2 -> bus shows 6,6,0,F; no DATA nibbles; Done pulses once.
REQ-038 WaitReq held high with MAX_WAIT=8 -> bus shows eight 0x6 nibbles, then 0xA, then 0xF, LpcOe=0, Done.
REQ-039 Abort during the 2nd DATA nibble -> LpcOe=0 on the next clock, Busy=0, no Done; a new Start with Claim=0 gets no response.
REQ-040 PciReset low during SYNC, then Start on the first clock after release -> a clean response, identical to REQ-035.
